// File: rtl/pcie_rq_pkg.sv
// Shared sideband layout, FSM encoding and helpers for the RQ arbiter.
// Included by pcie_rq_arb and its sub-modules via import pcie_rq_pkg::*.
package pcie_rq_pkg;

  localparam int SOP_B  = 15;
  localparam int EOP_B  = 14;
  localparam int ERR_B  = 13;
  localparam int KEEP_L = 8;
  localparam int FBE_L  = 4;
  localparam int LBE_L  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
  } state_e;

  // Synthetic close-out beat: EOP+ERR, empty keep and byte enables.
  localparam logic [15:0] TMO_EX =
    16'((1 << EOP_B) | (1 << ERR_B)
      | (0 << KEEP_L) | (0 << FBE_L) | (0 << LBE_L));

  function automatic logic [1:0] rr_next(
    input logic [1:0] id,
    input int         n
  );
    if (int'(id) + 1 >= n) return 2'd0;
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among up to four requesters.
// Search starts at ptr and wraps modulo N.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   idx
);

  logic [3:0] req4;
  logic [2:0] pos;
  logic       hit;

  assign req4 = 4'(req);
  assign gnt  = hit ? (N'(1) << idx) : '0;

  always_comb begin
    idx = '0;
    hit = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + 3'(k);
      if (pos >= 3'(N)) pos = pos - 3'(N);
      if (!hit && req4[pos[1:0]]) begin
        hit = 1'b1;
        idx = pos[1:0];
      end
    end
  end

endmodule

// File: rtl/pcie_rq_arb.sv
// Packet-locked round-robin arbiter feeding the PCIe RQ interface FIFO.
// Define PCIE_RQ_ARB_TIMEOUT_EN to close out stalled packets after TIMEOUT_CYC.
module pcie_rq_arb #(
  parameter int DWIDTH      = 256,
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ*16-1:0]     req_data_ex,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  output logic [DWIDTH-1:0]      rq_oper_data,
  output logic [15:0]            rq_oper_data_ex,
  output logic                   rq_oper_wen,
  input  logic                   rq_oper_ready,
  output logic [15:0]            odbg_info
);
  import pcie_rq_pkg::*;

  if (!(DWIDTH == 256 || DWIDTH == 128) || NREQ < 2
      || NREQ > 4 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("pcie_rq_arb: illegal parameter set");
  end

  logic [DWIDTH-1:0] dat_a [4];
  logic [15:0]       ex_a  [4];
  logic [3:0]        vld4;
  logic [NREQ-1:0]   sop_v;
  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   arb_gnt;
  logic [1:0]        arb_idx;
  logic [NREQ-1:0]   rdy;

  state_e            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        owner_q, owner_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [15:0]       ex_q, ex_d;
  logic              wen_q, wen_d;
  logic              perr_q, perr_d;
  logic              tout_flg;
  logic [3:0]        tout_cnt;

  for (genvar i = 0; i < 4; i++) begin : g_slot
    if (i < NREQ) begin : g_on
      assign dat_a[i] = req_data[i*DWIDTH +: DWIDTH];
      assign ex_a[i]  = req_data_ex[i*16 +: 16];
      assign vld4[i]  = req_valid[i];
    end else begin : g_off
      assign dat_a[i] = '0;
      assign ex_a[i]  = '0;
      assign vld4[i]  = 1'b0;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_sop
    assign sop_v[i] = req_valid[i] & req_data_ex[i*16+SOP_B];
  end

  // Without any SOP candidate, stray mid-packet beats are arbitrated for drop.
  assign arb_req = (|sop_v) ? sop_v : req_valid;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

`ifdef PCIE_RQ_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] stall_q, stall_d;
  logic          tflg_q, tflg_d;
  logic [3:0]    tcnt_q, tcnt_d;

  assign tout_flg = tflg_q;
  assign tout_cnt = tcnt_q;
`else
  assign tout_flg = 1'b0;
  assign tout_cnt = 4'd0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    ex_d     = ex_q;
    wen_d    = 1'b0;
    perr_d   = perr_q;
    rdy      = '0;
`ifdef PCIE_RQ_ARB_TIMEOUT_EN
    stall_d  = stall_q;
    tflg_d   = tflg_q;
    tcnt_d   = tcnt_q;
`endif
    unique case (1'b1)
      state_q == ST_IDLE: begin
`ifdef PCIE_RQ_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
        if (rq_oper_ready && (|arb_req)) begin
          rdy = arb_gnt;
          if (ex_a[arb_idx][SOP_B]) begin
            data_d  = dat_a[arb_idx];
            ex_d    = ex_a[arb_idx];
            wen_d   = 1'b1;
            owner_d = arb_idx;
            if (ex_a[arb_idx][EOP_B]) begin
              rr_ptr_d = rr_next(arb_idx, NREQ);
            end else begin
              state_d = ST_BUSY;
            end
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      state_q == ST_BUSY: begin
        if (rq_oper_ready && vld4[owner_q]) begin
          rdy    = NREQ'(1) << owner_q;
          data_d = dat_a[owner_q];
          ex_d   = ex_a[owner_q];
          wen_d  = 1'b1;
`ifdef PCIE_RQ_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (ex_a[owner_q][SOP_B]) begin
            ex_d[ERR_B] = 1'b1;
            perr_d      = 1'b1;
          end
          if (ex_a[owner_q][EOP_B]) begin
            state_d  = ST_IDLE;
            rr_ptr_d = rr_next(owner_q, NREQ);
          end
        end
`ifdef PCIE_RQ_ARB_TIMEOUT_EN
        else if (!vld4[owner_q]) begin
          if (stall_q >= TW'(TIMEOUT_CYC - 1)) begin
            if (rq_oper_ready) begin
              data_d   = '0;
              ex_d     = TMO_EX;
              wen_d    = 1'b1;
              tflg_d   = 1'b1;
              tcnt_d   = (tcnt_q == 4'hF) ? tcnt_q : tcnt_q + 4'd1;
              rr_ptr_d = rr_next(owner_q, NREQ);
              state_d  = ST_IDLE;
              stall_d  = '0;
            end
          end else begin
            stall_d = stall_q + TW'(1);
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      data_q   <= '0;
      ex_q     <= '0;
      wen_q    <= 1'b0;
      perr_q   <= 1'b0;
`ifdef PCIE_RQ_ARB_TIMEOUT_EN
      stall_q  <= '0;
      tflg_q   <= 1'b0;
      tcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      ex_q     <= ex_d;
      wen_q    <= wen_d;
      perr_q   <= perr_d;
`ifdef PCIE_RQ_ARB_TIMEOUT_EN
      stall_q  <= stall_d;
      tflg_q   <= tflg_d;
      tcnt_q   <= tcnt_d;
`endif
    end
  end

  assign req_ready       = user_rst_n ? rdy : '0;
  assign rq_oper_data    = data_q;
  assign rq_oper_data_ex = ex_q;
  assign rq_oper_wen     = wen_q;

  assign odbg_info = {state_q, owner_q, rr_ptr_q, perr_q,
                      tout_flg, 3'b000, tout_cnt, rq_oper_ready};

endmodule

// File: tb/tb_pcie_rq_arb.sv
// Directed vector bench for pcie_rq_arb (2 requesters, 256-bit data).
// Build with PCIE_RQ_ARB_TIMEOUT_EN to exercise the stall close-out path.
module tb_pcie_rq_arb;

  localparam int DW = 256;
  localparam int NR = 2;

  localparam logic [15:0] S  = 16'h8F11;
  localparam logic [15:0] M  = 16'h0F22;
  localparam logic [15:0] E  = 16'h4F33;
  localparam logic [15:0] SE = 16'hCF44;
  localparam logic [15:0] S2 = 16'h8F55;
  localparam logic [15:0] S2E = 16'hAF55;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ordy = 1'b0;
  logic [1:0]     vld = '0;
  logic [15:0]    ex0 = '0, ex1 = '0;
  logic [7:0]     d0 = '0, d1 = '0;
  logic [NR*DW-1:0] req_data;
  logic [NR*16-1:0] req_data_ex;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  rq_oper_data;
  logic [15:0]    rq_oper_data_ex;
  logic           rq_oper_wen;
  logic [15:0]    odbg_info;

  int n_run = 0;
  int n_fail = 0;

  assign req_data    = {{(DW/8){d1}}, {(DW/8){d0}}};
  assign req_data_ex = {ex1, ex0};

  always #5 clk = ~clk;

  pcie_rq_arb #(
    .DWIDTH      (DW),
    .NREQ        (NR),
    .TIMEOUT_CYC (16)
  ) dut (
    .user_clk        (clk),
    .user_rst_n      (rst_n),
    .req_data        (req_data),
    .req_data_ex     (req_data_ex),
    .req_valid       (vld),
    .req_ready       (req_ready),
    .rq_oper_data    (rq_oper_data),
    .rq_oper_data_ex (rq_oper_data_ex),
    .rq_oper_wen     (rq_oper_wen),
    .rq_oper_ready   (ordy),
    .odbg_info       (odbg_info)
  );

  typedef struct {
    logic        rst;
    logic        ordy;
    logic [1:0]  vld;
    logic [15:0] ex0;
    logic [7:0]  d0;
    logic [15:0] ex1;
    logic [7:0]  d1;
    logic [1:0]  e_rdy;
    logic        e_wen;
    logic        e_chk;
    logic [15:0] e_ex;
    logic [7:0]  e_d;
    logic [1:0]  e_st;
    logic [1:0]  e_ptr;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic o, input logic [1:0] v,
    input logic [15:0] x0, input logic [7:0] a0,
    input logic [15:0] x1, input logic [7:0] a1,
    input logic [1:0] er, input logic ew, input logic ec,
    input logic [15:0] ex, input logic [7:0] ed,
    input logic [1:0] es, input logic [1:0] ep, input logic epe
  );
    vec_t t;
    t.rst = r; t.ordy = o; t.vld = v;
    t.ex0 = x0; t.d0 = a0; t.ex1 = x1; t.d1 = a1;
    t.e_rdy = er; t.e_wen = ew; t.e_chk = ec;
    t.e_ex = ex; t.e_d = ed;
    t.e_st = es; t.e_ptr = ep; t.e_perr = epe;
    return t;
  endfunction

  task automatic check(
    input string nm, input int k,
    input logic [255:0] act, input logic [255:0] exp
  );
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  task automatic put(
    input logic r, input logic o, input logic [1:0] v,
    input logic [15:0] x0, input logic [7:0] a0,
    input logic [15:0] x1, input logic [7:0] a1
  );
    @(negedge clk);
    rst_n = r; ordy = o; vld = v;
    ex0 = x0; d0 = a0; ex1 = x1; d1 = a1;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // reset
    vecs.push_back(mk(0,1,0, 0,0, 0,0, 0, 0,1, 0,0, 0,0,0));
    // two 3-beat packets, req0 first, no interleave
    vecs.push_back(mk(1,1,3, S,8'h11, S,8'h21, 1, 1,1, S,8'h11, 1,0,0));
    vecs.push_back(mk(1,1,3, M,8'h12, S,8'h21, 1, 1,1, M,8'h12, 1,0,0));
    vecs.push_back(mk(1,1,3, E,8'h13, S,8'h21, 1, 1,1, E,8'h13, 0,1,0));
    vecs.push_back(mk(1,1,2, 0,0, S,8'h21, 2, 1,1, S,8'h21, 1,1,0));
    vecs.push_back(mk(1,1,2, 0,0, M,8'h22, 2, 1,1, M,8'h22, 1,1,0));
    vecs.push_back(mk(1,1,2, 0,0, E,8'h23, 2, 1,1, E,8'h23, 0,0,0));
    // 4-beat packet, 5 cycles of backpressure after beat 2
    vecs.push_back(mk(1,1,1, S,8'h31, 0,0, 1, 1,1, S,8'h31, 1,0,0));
    vecs.push_back(mk(1,1,1, M,8'h32, 0,0, 1, 1,1, M,8'h32, 1,0,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,0,3, M,8'h33, SE,8'h41, 0, 0,0, 0,0, 1,0,0));
    vecs.push_back(mk(1,1,3, M,8'h33, SE,8'h41, 1, 1,1, M,8'h33, 1,0,0));
    vecs.push_back(mk(1,1,3, E,8'h34, SE,8'h41, 1, 1,1, E,8'h34, 0,1,0));
    // single-beat packets from req1 against a 2-beat req0 packet
    vecs.push_back(mk(1,1,3, S,8'h51, SE,8'h41, 2, 1,1, SE,8'h41, 0,0,0));
    vecs.push_back(mk(1,1,3, S,8'h51, SE,8'h42, 1, 1,1, S,8'h51, 1,0,0));
    vecs.push_back(mk(1,1,3, E,8'h52, SE,8'h42, 1, 1,1, E,8'h52, 0,1,0));
    vecs.push_back(mk(1,1,2, 0,0, SE,8'h42, 2, 1,1, SE,8'h42, 0,0,0));
    vecs.push_back(mk(1,1,2, 0,0, SE,8'h43, 2, 1,1, SE,8'h43, 0,0,0));
    vecs.push_back(mk(1,1,2, 0,0, SE,8'h44, 2, 1,1, SE,8'h44, 0,0,0));
    // non-SOP beat in IDLE is swallowed
    vecs.push_back(mk(1,1,1, M,8'h61, 0,0, 1, 0,0, 0,0, 0,0,1));
    vecs.push_back(mk(1,1,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,1));
    // repeated SOP inside a packet gets ERR forced
    vecs.push_back(mk(1,1,1, S,8'h71, 0,0, 1, 1,1, S,8'h71, 1,0,1));
    vecs.push_back(mk(1,1,1, S2,8'h72, 0,0, 1, 1,1, S2E,8'h72, 1,0,1));
    vecs.push_back(mk(1,1,1, E,8'h73, 0,0, 1, 1,1, E,8'h73, 0,1,1));
    // no grant while downstream not ready
    vecs.push_back(mk(1,0,3, S,8'h81, S,8'h91, 0, 0,0, 0,0, 0,1,1));
    vecs.push_back(mk(1,1,3, S,8'h81, S,8'h91, 2, 1,1, S,8'h91, 1,1,1));
    // reset on beat 2, then the orphaned tail is dropped
    vecs.push_back(mk(0,1,3, S,8'h81, M,8'h92, 0, 0,1, 0,0, 0,0,0));
    vecs.push_back(mk(1,1,0, 0,0, 0,0, 0, 0,1, 0,0, 0,0,0));
    vecs.push_back(mk(1,1,2, 0,0, E,8'h94, 2, 0,0, 0,0, 0,0,1));
    vecs.push_back(mk(1,1,0, 0,0, 0,0, 0, 0,0, 0,0, 0,0,1));

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      put(v.rst, v.ordy, v.vld, v.ex0, v.d0, v.ex1, v.d1);
      check("req_ready", k, 256'(req_ready), 256'(v.e_rdy));
      tick();
      check("wen", k, 256'(rq_oper_wen), 256'(v.e_wen));
      check("state", k, 256'(odbg_info[15:14]), 256'(v.e_st));
      check("rr_ptr", k, 256'(odbg_info[11:10]), 256'(v.e_ptr));
      check("proto_err", k, 256'(odbg_info[9]), 256'(v.e_perr));
      check("tout", k, 256'(odbg_info[8:1]), 256'(0));
      if (v.e_chk) begin
        check("data", k, rq_oper_data, {(DW/8){v.e_d}});
        check("ex", k, 256'(rq_oper_data_ex), 256'(v.e_ex));
      end
    end

    // owner stalls mid-packet while req1 has a packet pending
    put(0, 1, 0, 0, 0, 0, 0);
    tick();
    put(1, 1, 3, S, 8'hA1, SE, 8'hB1);
    check("tmo_sop_rdy", 100, 256'(req_ready), 256'(1));
    tick();
    check("tmo_sop_ex", 100, 256'(rq_oper_data_ex), 256'(S));
`ifdef PCIE_RQ_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      put(1, 1, 2, 0, 0, SE, 8'hB1);
      check("tmo_rdy", 100 + i, 256'(req_ready), 256'(0));
      tick();
      check("tmo_wen", 100 + i, 256'(rq_oper_wen), 256'(i == 16));
    end
    check("tmo_ex", 117, 256'(rq_oper_data_ex), 256'(16'h6000));
    check("tmo_data", 117, rq_oper_data, 256'(0));
    check("tout_cnt", 117, 256'(odbg_info[4:1]), 256'(1));
    check("tout_flg", 117, 256'(odbg_info[8]), 256'(1));
    check("tmo_state", 117, 256'(odbg_info[15:14]), 256'(0));
    check("tmo_ptr", 117, 256'(odbg_info[11:10]), 256'(1));
    put(1, 1, 2, 0, 0, SE, 8'hB1);
    check("tmo_next_rdy", 118, 256'(req_ready), 256'(2));
    tick();
    check("tmo_next_ex", 118, 256'(rq_oper_data_ex), 256'(SE));
    check("tmo_next_d", 118, rq_oper_data, {(DW/8){8'hB1}});
`else
    for (int i = 1; i <= 20; i++) begin
      put(1, 1, 2, 0, 0, SE, 8'hB1);
      check("hold_rdy", 100 + i, 256'(req_ready), 256'(0));
      tick();
      check("hold_wen", 100 + i, 256'(rq_oper_wen), 256'(0));
    end
    check("hold_state", 121, 256'(odbg_info[15:14]), 256'(1));
    check("hold_tout", 121, 256'(odbg_info[8:1]), 256'(0));
    put(1, 1, 3, E, 8'hA2, SE, 8'hB1);
    check("hold_eop_rdy", 122, 256'(req_ready), 256'(1));
    tick();
    check("hold_eop_ex", 122, 256'(rq_oper_data_ex), 256'(E));
    put(1, 1, 2, 0, 0, SE, 8'hB1);
    check("hold_next_rdy", 123, 256'(req_ready), 256'(2));
    tick();
    check("hold_next_d", 123, rq_oper_data, {(DW/8){8'hB1}});
`endif
    put(1, 1, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_rq_arb.md
PCIE_RQ_ARB -- requirements
Module: pcie_rq_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 256, meaning data width in bits; only 256 or 128 are legal.
REQ-002 SHALL have parameter NREQ, default 2, meaning number of requesters; legal range 2..4.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning mid-packet stall limit in cycles.
REQ-004 SHALL use one clock, user_clk, with synchronous active-low reset user_rst_n.
REQ-005 user_clk  in  1  sole clock.
REQ-006 user_rst_n  in  1  synchronous, active-low reset.
REQ-007 req_data  in  NREQ*DWIDTH  per-requester beat data; requester i occupies slice [i*DWIDTH +: DWIDTH].
REQ-008 req_data_ex  in  NREQ*16  per-requester sideband: bit15 SOP, bit14 EOP, bit13 ERR, [11:8] keep, [7:4] first_be, [3:0] last_be.
REQ-009 req_valid  in  NREQ  per-requester beat valid.
REQ-010 req_ready  out  NREQ  per-requester beat accept.
REQ-011 rq_oper_data  out  DWIDTH  arbitrated beat data.
REQ-012 rq_oper_data_ex  out  16  arbitrated sideband, same format as req_data_ex.
REQ-013 rq_oper_wen  out  1  write strobe to the RQ interface FIFO.
REQ-014 rq_oper_ready  in  1  registered not-almost-full from the RQ interface.
REQ-015 odbg_info  out  16  debug status: {state, grant_id[1:0], rr_ptr[1:0], proto_err, tout_flg, 3'b0, tout_cnt[3:0], rq_oper_ready}.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-017 In IDLE, arbitration candidates SHALL be requesters with req_valid=1 and SOP=1; grant SHALL go round-robin, starting at rr_ptr.
REQ-018 A grant SHALL be issued only when rq_oper_ready=1.
REQ-019 req_ready[i] SHALL be 1 only for the granted index, only when rq_oper_ready=1, and only for the accepting beat; all other bits SHALL be 0.
REQ-020 An accepted beat SHALL appear on rq_oper_data/rq_oper_data_ex with rq_oper_wen=1 exactly one cycle after acceptance (registered output).
REQ-021 An SOP beat without EOP SHALL move the FSM IDLE->BUSY; a single-beat packet (SOP and EOP) SHALL keep it in IDLE.
REQ-022 In BUSY, the grant SHALL lock to the owner until its EOP beat is accepted; BUSY->IDLE SHALL occur on EOP acceptance.
REQ-023 On EOP acceptance, rr_ptr SHALL become (owner+1) mod NREQ.
REQ-024 In BUSY, beats SHALL pass only while rq_oper_ready=1; when ready=0 the FSM SHALL hold without loss.
REQ-025 In IDLE, a valid beat with SOP=0 SHALL be accepted and dropped (no wen); sticky proto_err SHALL be set.
REQ-026 In BUSY, an owner beat with SOP=1 SHALL be forwarded with ERR forced to 1 and proto_err set; the packet SHALL continue.
REQ-027 Simultaneous SOP requests SHALL be resolved purely by rr_ptr order; there SHALL be no fixed priority.
REQ-028 Back-to-back packets SHALL be possible: an EOP beat and the next SOP grant MAY occur in consecutive cycles (zero idle cycles).
REQ-029 rq_oper_wen SHALL never assert unless rq_oper_ready was 1 in the acceptance cycle.

Reset
REQ-030 With user_rst_n=0 at a clock edge, the FSM SHALL go to IDLE and rr_ptr to 0, with rq_oper_wen=0, rq_oper_data=0, rq_oper_data_ex=0, req_ready=0, proto_err=0, tout_flg=0, tout_cnt=0.
REQ-031 Reset mid-packet SHALL abandon the packet with no EOP emitted; the downstream FIFO reset is owned elsewhere.

Configuration
REQ-032 Macro PCIE_RQ_ARB_TIMEOUT_EN defined: in BUSY, a stall counter SHALL count cycles with owner req_valid=0.
REQ-033 The stall counter SHALL clear on each accepted beat. On reaching TIMEOUT_CYC with rq_oper_ready=1, the block SHALL emit one beat: data 0, SOP=0, EOP=1, ERR=1, keep=0, first_be and last_be of 0.
REQ-034 On that timeout beat, the block SHALL set tout_flg, increment tout_cnt (saturating at 15), advance rr_ptr and return to IDLE.
REQ-035 Macro undefined: no stall counter SHALL exist; BUSY SHALL wait indefinitely; tout_flg and tout_cnt SHALL read constant 0.

Structure
REQ-036 The shared package pcie_rq_pkg SHALL hold the sideband bit positions (SOP=15, EOP=14, ERR=13, KEEP_L=8, FBE_L=4, LBE_L=0) and the FSM state encoding.
REQ-037 The round-robin selection SHALL live in one sub-module, rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant plus index).

Verification
REQ-038 Arbitration: req0 and req1 each present a 3-beat packet at reset with rr_ptr=0 -> req0 beats at cycles 1-3 and req1 at 4-6 on rq_oper_wen, with no interleave; rr_ptr then reads 0.
REQ-039 Backpressure: rq_oper_ready=0 for 5 cycles after beat 2 of a 4-beat packet -> wen is low for those 5 cycles, beats 3-4 follow once ready returns, and all beats are delivered in order.
REQ-040 Single-beat packets: req1 sends 4 single-beat (SOP+EOP) packets while req0 waits with a 2-beat packet -> grants alternate 1,0,1,1,1; FSM stays IDLE across all single-beat packets.
REQ-041 Protocol error: req0 sends SOP=0 in IDLE -> beat dropped, proto_err=1, and no wen.
REQ-042 Timeout with PCIE_RQ_ARB_TIMEOUT_EN and TIMEOUT_CYC=16: req0 sends SOP then drops valid -> after 16 cycles one beat with ex=16'h6000 appears, tout_cnt=1, and req1's pending packet is granted next.
REQ-043 Reset asserted during beat 2 of a 4-beat packet -> next cycle all outputs are 0, FSM is IDLE, and no partial EOP is emitted.
